// File: rtl/fp_add_arbiter_if.sv
// Bundle of requester, adder and response signals around the shared FP adder controller.
// The slave modport is the controller's view; master is the environment's view.
interface fp_add_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [WIDTH-1:0] add_para1;
    logic [WIDTH-1:0] add_para2;
    logic [WIDTH-1:0] add_out;
    logic             add_under_overflow;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_flag;
    logic             busy;
    logic [7:0]       ovf_count;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output add_para1, add_para2,
        input  add_out, add_under_overflow,
        output rsp_valid, rsp_id, rsp_data, rsp_flag,
        input  rsp_ready,
        output busy, ovf_count
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  add_para1, add_para2,
        output add_out, add_under_overflow,
        input  rsp_valid, rsp_id, rsp_data, rsp_flag,
        output rsp_ready,
        input  busy, ovf_count
    );
endinterface

// File: rtl/fp_add_arbiter.sv
// Round-robin sequencer sharing one combinational FP adder between two requesters:
// grant, hold operands for SETTLE_CYCLES, capture sum/flag, return via valid/ready.
module fp_add_arbiter #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    fp_add_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t           state_reg;
    state_t           state_next;
    logic             last_grant_reg;
    logic [3:0]       cnt_reg;
    logic [WIDTH-1:0] para1_reg;
    logic [WIDTH-1:0] para2_reg;
    logic [WIDTH-1:0] data_reg;
    logic             flag_reg;
    logic             rsp_id_reg;
    logic [7:0]       ovf_reg;

    logic [1:0]       req_valid;
    logic [1:0]       grant;
    logic [WIDTH-1:0] req_a [2];
    logic [WIDTH-1:0] req_b [2];

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign req_a[0]  = bus.req0_a;
    assign req_a[1]  = bus.req1_a;
    assign req_b[0]  = bus.req0_b;
    assign req_b[1]  = bus.req1_b;

    // A requester wins when alone, or on a tie when the other one was served last.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_grant
            assign grant[gi] = (state_reg == IDLE) && req_valid[gi] &&
                               (!req_valid[1-gi] || (last_grant_reg == (gi == 0)));
        end
    endgenerate

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];
    assign bus.add_para1  = para1_reg;
    assign bus.add_para2  = para2_reg;
    assign bus.rsp_valid  = (state_reg == RESP);
    assign bus.rsp_id     = rsp_id_reg;
    assign bus.rsp_data   = data_reg;
    assign bus.rsp_flag   = flag_reg;
    assign bus.busy       = (state_reg != IDLE);
    assign bus.ovf_count  = ovf_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (|grant) state_next = SETTLE;
            SETTLE:  if (cnt_reg == 4'd0) state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_reg <= 1'b1;
            cnt_reg        <= 4'd0;
            para1_reg      <= '0;
            para2_reg      <= '0;
            data_reg       <= '0;
            flag_reg       <= 1'b0;
            rsp_id_reg     <= 1'b0;
            ovf_reg        <= 8'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|grant) begin
                        para1_reg      <= grant[1] ? req_a[1] : req_a[0];
                        para2_reg      <= grant[1] ? req_b[1] : req_b[0];
                        rsp_id_reg     <= grant[1];
                        last_grant_reg <= grant[1];
                        cnt_reg        <= SETTLE_LOAD;
                    end
                end
                SETTLE: begin
                    // Operands have been stable for SETTLE_CYCLES edges; sample the adder now.
                    if (cnt_reg == 4'd0) begin
                        data_reg <= bus.add_out;
                        flag_reg <= bus.add_under_overflow;
                        if (bus.add_under_overflow && (ovf_reg != 8'hFF)) begin
                            ovf_reg <= ovf_reg + 8'd1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Randomized bench for fp_add_arbiter at SETTLE_CYCLES of 2, 1 and 15, checked against
// a transaction-level model of grant order, response timing and overflow counting.
module tb_fp_add_arbiter;
    localparam logic [31:0] F_ONE  = 32'h3F80_0000;
    localparam logic [31:0] F_1P5  = 32'h3FC0_0000;
    localparam logic [31:0] F_2P5  = 32'h4020_0000;
    localparam logic [31:0] F_BIG  = 32'h7F00_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a       [3];
    logic        tb_req0_valid [3];
    logic        tb_req1_valid [3];
    logic [31:0] tb_req0_a [3];
    logic [31:0] tb_req0_b [3];
    logic [31:0] tb_req1_a [3];
    logic [31:0] tb_req1_b [3];
    logic        tb_rsp_ready [3];
    logic        req0_ready_o [3];
    logic        req1_ready_o [3];
    logic [31:0] para1_o [3];
    logic [31:0] para2_o [3];
    logic        rsp_valid_o [3];
    logic        rsp_id_o [3];
    logic [31:0] rsp_data_o [3];
    logic        rsp_flag_o [3];
    logic        busy_o [3];
    logic [7:0]  ovf_o [3];

    // Stand-in for the adder: exact results for the known float cases, a fixed scramble otherwise.
    function automatic logic [32:0] adder_model(input logic [31:0] a, input logic [31:0] b);
        if (a == F_ONE && b == F_ONE) return {1'b0, 32'h4000_0000};
        if (a == F_1P5 && b == F_2P5) return {1'b0, 32'h4080_0000};
        if (a == F_BIG && b == F_BIG) return {1'b1, 32'h7F80_0000};
        return {a[7] & b[3], (a + {b[30:0], 1'b0}) ^ 32'h5A5A_5A5A};
    endfunction

    function automatic int settle_of(input int i);
        return (i == 0) ? 2 : (i == 1) ? 1 : 15;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            localparam int S = (gi == 0) ? 2 : (gi == 1) ? 1 : 15;
            fp_add_arbiter_if #(.WIDTH(32)) bus ();
            logic [32:0] sum;
            assign bus.req0_valid = tb_req0_valid[gi];
            assign bus.req0_a     = tb_req0_a[gi];
            assign bus.req0_b     = tb_req0_b[gi];
            assign bus.req1_valid = tb_req1_valid[gi];
            assign bus.req1_a     = tb_req1_a[gi];
            assign bus.req1_b     = tb_req1_b[gi];
            assign bus.rsp_ready  = tb_rsp_ready[gi];
            assign sum            = adder_model(bus.add_para1, bus.add_para2);
            assign bus.add_out    = sum[31:0];
            assign bus.add_under_overflow = sum[32];
            assign req0_ready_o[gi] = bus.req0_ready;
            assign req1_ready_o[gi] = bus.req1_ready;
            assign para1_o[gi]      = bus.add_para1;
            assign para2_o[gi]      = bus.add_para2;
            assign rsp_valid_o[gi]  = bus.rsp_valid;
            assign rsp_id_o[gi]     = bus.rsp_id;
            assign rsp_data_o[gi]   = bus.rsp_data;
            assign rsp_flag_o[gi]   = bus.rsp_flag;
            assign busy_o[gi]       = bus.busy;
            assign ovf_o[gi]        = bus.ovf_count;
            fp_add_arbiter #(.WIDTH(32), .SETTLE_CYCLES(S)) u_dut (
                .clk (clk),
                .rst (rst_a[gi]),
                .bus (bus.slave)
            );
        end
    endgenerate

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int cur_s    = 0;

    // Reference model: what the controller owes the outside world.
    bit          m_busy;
    bit          m_last;
    bit          m_id;
    bit          m_flag;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [31:0] m_data;
    int          m_acc;
    int          m_ovf;
    logic [63:0] q0 [$];
    logic [63:0] q1 [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL s=%0d cyc=%0d %s got=%h exp=%h", cur_s, cyc, tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_last = 1'b1; m_id = 1'b0; m_flag = 1'b0;
        m_a = '0; m_b = '0; m_data = '0; m_acc = 0; m_ovf = 0;
    endtask

    task automatic check_state(input int i, input bit e_r0, input bit e_r1, input bit e_rv);
        check("req0_ready", 32'(req0_ready_o[i]), 32'(e_r0));
        check("req1_ready", 32'(req1_ready_o[i]), 32'(e_r1));
        check("busy",       32'(busy_o[i]),       32'(m_busy));
        check("rsp_valid",  32'(rsp_valid_o[i]),  32'(e_rv));
        check("ovf_count",  32'(ovf_o[i]),        32'(m_ovf));
        check("add_para1",  para1_o[i],           m_a);
        check("add_para2",  para2_o[i],           m_b);
        check("rsp_id",     32'(rsp_id_o[i]),     32'(m_id));
        check("rsp_data",   rsp_data_o[i],        m_data);
        check("rsp_flag",   32'(rsp_flag_o[i]),   32'(m_flag));
    endtask

    task automatic do_reset(input int i);
        rst_a[i] = 1'b1;
        tb_req0_valid[i] = 1'b0; tb_req1_valid[i] = 1'b0; tb_rsp_ready[i] = 1'b0;
        tick();
        tick();
        model_reset();
        check_state(i, 1'b0, 1'b0, 1'b0);
        rst_a[i] = 1'b0;
    endtask

    // rdy_mode: 0 = ready tied high, 1 = random, 2 = withhold for 10 response cycles
    task automatic run_ops(input int i, input int rdy_mode, input bit b2b, input int budget);
        int s = settle_of(i);
        int k = 0;
        int stall = 0;
        int last_acc = -1;
        bit v0 = 1'b0;
        bit v1 = 1'b0;
        bit e_r0, e_r1, e_rv, hs;
        logic [32:0] r;
        while ((q0.size() > 0 || q1.size() > 0 || m_busy) && k < budget) begin
            if (!v0 && q0.size() > 0 && (rdy_mode != 1 || $urandom_range(1, 0) == 1)) v0 = 1'b1;
            if (!v1 && q1.size() > 0 && (rdy_mode != 1 || $urandom_range(1, 0) == 1)) v1 = 1'b1;
            tb_req0_valid[i] = v0;
            tb_req1_valid[i] = v1;
            tb_req0_a[i] = v0 ? q0[0][63:32] : $urandom();
            tb_req0_b[i] = v0 ? q0[0][31:0]  : $urandom();
            tb_req1_a[i] = v1 ? q1[0][63:32] : $urandom();
            tb_req1_b[i] = v1 ? q1[0][31:0]  : $urandom();
            e_rv = m_busy && (cyc >= m_acc + s);
            case (rdy_mode)
                0: tb_rsp_ready[i] = 1'b1;
                1: tb_rsp_ready[i] = ($urandom_range(3, 0) != 0);
                default: begin
                    if (e_rv && stall < 10) begin
                        tb_rsp_ready[i] = 1'b0;
                        stall++;
                    end else begin
                        tb_rsp_ready[i] = 1'b1;
                    end
                end
            endcase
            #1;
            if (m_busy && cyc == m_acc + s) begin
                r = adder_model(m_a, m_b);
                m_data = r[31:0];
                m_flag = r[32];
                if (m_flag && m_ovf < 255) m_ovf++;
            end
            e_r0 = !m_busy && v0 && (!v1 || m_last);
            e_r1 = !m_busy && v1 && (!v0 || !m_last);
            check_state(i, e_r0, e_r1, e_rv);
            hs = e_rv && tb_rsp_ready[i];
            if (hs) $display("s=%0d cyc=%0d rsp id=%0d data=%h flag=%0d ovf=%0d",
                             s, cyc, rsp_id_o[i], rsp_data_o[i], rsp_flag_o[i], ovf_o[i]);
            tick();
            k++;
            if (hs) m_busy = 1'b0;
            if (e_r0 || e_r1) begin
                if (e_r0) begin
                    {m_a, m_b} = q0.pop_front();
                    m_id = 1'b0;
                    v0 = 1'b0;
                end else begin
                    {m_a, m_b} = q1.pop_front();
                    m_id = 1'b1;
                    v1 = 1'b0;
                end
                m_last = m_id;
                m_busy = 1'b1;
                m_acc  = cyc;
                if (b2b && last_acc >= 0) check("accept_period", 32'(cyc - last_acc), 32'(s + 2));
                last_acc = cyc;
            end
        end
        if (k >= budget) check("ops_left_at_budget", 32'(q0.size() + q1.size() + int'(m_busy)), 32'd0);
        tb_req0_valid[i] = 1'b0;
        tb_req1_valid[i] = 1'b0;
        tb_rsp_ready[i]  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        for (int i = 0; i < 3; i++) begin
            rst_a[i] = 1'b1;
            tb_req0_valid[i] = 1'b0; tb_req1_valid[i] = 1'b0; tb_rsp_ready[i] = 1'b0;
            tb_req0_a[i] = '0; tb_req0_b[i] = '0; tb_req1_a[i] = '0; tb_req1_b[i] = '0;
        end
        for (int i = 0; i < 3; i++) begin
            s = settle_of(i);
            cur_s = s;
            do_reset(i);

            q0.push_back({F_ONE, F_ONE});
            run_ops(i, 0, 1'b0, 20 * (s + 2));
            check("single_data", rsp_data_o[i], 32'h4000_0000);
            check("single_id", 32'(rsp_id_o[i]), 32'd0);
            check("single_flag", 32'(rsp_flag_o[i]), 32'd0);

            for (int n = 0; n < 3; n++) begin
                q0.push_back({F_ONE, F_ONE});
                q1.push_back({F_1P5, F_2P5});
            end
            run_ops(i, 0, 1'b1, 20 * (s + 2));

            q1.push_back({F_1P5, F_2P5});
            run_ops(i, 2, 1'b0, 40 * (s + 2));
            check("bp_data", rsp_data_o[i], 32'h4080_0000);
            check("bp_id", 32'(rsp_id_o[i]), 32'd1);
            check("bp_busy_after", 32'(busy_o[i]), 32'd0);

            for (int n = 0; n < 30; n++) begin
                if ($urandom_range(1, 0) == 1) q0.push_back({$urandom(), $urandom()});
                else                           q1.push_back({$urandom(), $urandom()});
            end
            run_ops(i, 1, 1'b0, 30 * (s + 2) * 8 + 100);

            if (i == 0) begin
                for (int n = 0; n < 300; n++) q0.push_back({F_BIG, F_BIG});
                run_ops(i, 0, 1'b1, 300 * (s + 2) + 50);
                check("ovf_saturated", 32'(ovf_o[i]), 32'd255);
                check("ovf_flag", 32'(rsp_flag_o[i]), 32'd1);

                // Start one op, then yank reset asynchronously in the middle of SETTLE.
                tb_req0_valid[i] = 1'b1; tb_req0_a[i] = F_ONE; tb_req0_b[i] = F_ONE;
                tb_req1_valid[i] = 1'b0; tb_rsp_ready[i] = 1'b1;
                #1;
                check("rst_pre_ready0", 32'(req0_ready_o[i]), 32'd1);
                tick();
                tb_req0_valid[i] = 1'b0;
                check("rst_pre_busy", 32'(busy_o[i]), 32'd1);
                #2;
                rst_a[i] = 1'b1;
                #1;
                check("rst_async_busy", 32'(busy_o[i]), 32'd0);
                check("rst_async_valid", 32'(rsp_valid_o[i]), 32'd0);
                check("rst_async_para1", para1_o[i], 32'd0);
                check("rst_async_para2", para2_o[i], 32'd0);
                check("rst_async_data", rsp_data_o[i], 32'd0);
                check("rst_async_flag", 32'(rsp_flag_o[i]), 32'd0);
                check("rst_async_ovf", 32'(ovf_o[i]), 32'd0);
                for (int n = 0; n < 4; n++) begin
                    tick();
                    check("rst_held_valid", 32'(rsp_valid_o[i]), 32'd0);
                end
                rst_a[i] = 1'b0;
                model_reset();
                q0.push_back({F_ONE, F_ONE});
                q1.push_back({F_1P5, F_2P5});
                run_ops(i, 0, 1'b1, 20 * (s + 2));
            end
            rst_a[i] = 1'b1;
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_add_arbiter.md
# fp_add_arbiter

Sequencing controller that shares one combinational floating-point adder (32-bit single-precision datapath, outputs `out` and `under_overflow`) between two requesters. It arbitrates round-robin, registers the winning operand pair onto the adder inputs, holds them stable for a programmable settle time, then captures the sum and overflow flag into a response register returned over a valid/ready handshake. It sits between the ALU's operand sources and the adder instance and is the only driver of the adder's inputs.

## Interface
- `WIDTH`, 32: operand/result width; must match the adder.
- `SETTLE_CYCLES`, 2: cycles the adder inputs are held before the result is captured; legal range 1..15.
- `clk` in 1: sole clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0_valid` in 1 / `req0_ready` out 1: requester 0 handshake.
- `req0_a`, `req0_b` in WIDTH: requester 0 operands.
- `req1_valid` in 1 / `req1_ready` out 1: requester 1 handshake.
- `req1_a`, `req1_b` in WIDTH: requester 1 operands.
- `add_para1`, `add_para2` out WIDTH: registered operands to adder `para1`/`para2`.
- `add_out` in WIDTH: adder `out`.
- `add_under_overflow` in 1: adder `under_overflow`.
- `rsp_valid` out 1 / `rsp_ready` in 1: response handshake.
- `rsp_id` out 1: requester index owning the response.
- `rsp_data` out WIDTH: captured sum.
- `rsp_flag` out 1: captured `under_overflow`.
- `busy` out 1: high in any state other than IDLE.
- `ovf_count` out 8: saturating count of responses with `rsp_flag`=1.

## Operation
- States: IDLE, SETTLE, RESP. Reset: IDLE, `last_grant`=1 (req0 wins first tie), all outputs 0, operand registers 0, `ovf_count` 0.
- Grant in IDLE only: `req0_ready` = IDLE & `req0_valid` & (!`req1_valid` | `last_grant`==1); `req1_ready` = IDLE & `req1_valid` & (!`req0_valid` | `last_grant`==0). At most one ready high; both 0 outside IDLE. Ready depends combinationally on valid; valid must not depend on ready.
- Accept (valid&ready high at edge): latch a→`add_para1`, b→`add_para2`, id→`rsp_id`, `last_grant`←id, load settle counter with SETTLE_CYCLES-1, go SETTLE.
- SETTLE: decrement counter each cycle; on the edge where counter==0, capture `add_out`→`rsp_data`, `add_under_overflow`→`rsp_flag`, set `rsp_valid`, go RESP; if flag set and `ovf_count`<255, increment.
- RESP: `rsp_valid`, `rsp_id`, `rsp_data`, `rsp_flag` held stable until `rsp_ready`; on handshake clear `rsp_valid`, go IDLE. No new request accepted in the handshake cycle.
- `add_para1/2` retain last operands after the op (no zeroing); `rsp_data`/`rsp_flag` retain last value after `rsp_valid` drops.
- Requests not granted must be held by requesters (valid stays, operands stable); a waiting requester is granted at the next IDLE if the other was last served.
- Sign/exponent semantics belong to the adder; controller never inspects data.
- `rst` asserted mid-operation: immediate return to reset values; in-flight op and pending response discarded; requesters re-present.

## Timing
- Accept at edge T: `add_para*` valid from T; capture at edge T+SETTLE_CYCLES; `rsp_valid` high from T+SETTLE_CYCLES.
- With `rsp_ready` tied high: response handshake at edge T+SETTLE_CYCLES+1, IDLE after it, next accept at edge T+SETTLE_CYCLES+2. Peak throughput one op per SETTLE_CYCLES+2 cycles.
- `rsp_ready` low stalls in RESP indefinitely; no data loss.
- `busy` registered (derived from state), low only in IDLE.

## Test plan
- Single op, SETTLE_CYCLES=2: req0 a=0x3F800000, b=0x3F800000 -> `rsp_valid` 2 cycles after accept, `rsp_id`=0, `rsp_data`=0x40000000, `rsp_flag`=0.
- Simultaneous valid both requesters continuously: grants alternate 0,1,0,1; req1 a=0x3FC00000, b=0x40200000 returns 0x40800000 with `rsp_id`=1.
- Backpressure: hold `rsp_ready`=0 for 10 cycles -> outputs stable, both readys 0, `busy`=1; release -> single handshake, IDLE next cycle.
- Overflow: a=b=0x7F000000 -> `rsp_flag`=1, `ovf_count` increments to 1; 300 such ops -> `ovf_count` saturates at 255.
- Reset mid-SETTLE: assert `rst` asynchronously -> all outputs 0 immediately, no response issued; after release req0 wins first tie.
- SETTLE_CYCLES=1 and 15: measured accept-to-`rsp_valid` latency equals parameter; back-to-back period equals parameter+2.
